// File: rtl/count_capture_fifo.sv
// Capture FIFO for snapshots of an upstream counter value. Each entry is tagged
// with a flag recording whether the counter wrapped since the previous capture.
module count_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] counter_in,
  input  logic          capture,
  output logic [CW:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          full,
  output logic [4:0]    level,
  output logic          overflow
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_LVL = 5'(DEPTH);

  logic [CW:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] prev_cnt;
  logic          prev_ok;
  logic          wrap_pending;
  logic          wrap_event;
  logic          push;
  logic          pop;
  logic          wrap_flag;

  assign out_valid  = (level != '0);
  assign full       = (level == DEPTH_LVL);
  assign pop        = out_valid && out_ready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign push       = capture && (!full || pop);
  assign wrap_event = enable && prev_ok && (prev_cnt == '1) && (counter_in == '0);
  assign wrap_flag  = wrap_pending || wrap_event;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      wrap_pending <= 1'b0;
      prev_ok      <= 1'b0;
      prev_cnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)
        level <= level + 5'd1;
      else if (pop && !push)
        level <= level - 5'd1;

      if (capture && !push)
        overflow <= 1'b1;

      // A dropped capture leaves a pending wrap for the next stored entry.
      if (push)
        wrap_pending <= 1'b0;
      else if (wrap_event)
        wrap_pending <= 1'b1;

      if (enable) begin
        prev_cnt <= counter_in;
        prev_ok  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset)
      mem[wr_ptr] <= {wrap_flag, counter_in};
  end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo (DEPTH=4, CW=4): a table of per-cycle
// vectors with hand-computed outputs, plus a hand-written hold/reset sequence.
module tb_count_capture_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] counter_in = '0;
  logic       capture = 1'b0;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       full;
  logic [4:0] level;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  count_capture_fifo #(.DEPTH(4), .CW(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .counter_in (counter_in),
    .capture    (capture),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .full       (full),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] cnt;
    logic       cap;
    logic       rdy;
    logic [4:0] e_data;
    logic       e_valid;
    logic [4:0] e_level;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  localparam int NV = 43;
  vec_t vecs [NV];
  int   nv = 0;

  task automatic add(input logic rst, input logic en, input logic [3:0] cnt,
                     input logic cap, input logic rdy, input logic [4:0] d,
                     input logic v, input logic [4:0] l, input logic f, input logic o);
    vecs[nv] = '{rst, en, cnt, cap, rdy, d, v, l, f, o};
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [3:0] cnt,
                      input logic cap, input logic rdy);
    reset = rst; enable = en; counter_in = cnt; capture = cap; out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //   rst en cnt  cap rdy | data   v  lvl f  ovf
    add(1, 0, 4'd0,  0, 0,  5'h00, 0, 0, 0, 0);   // 0  reset
    add(0, 1, 4'd5,  1, 0,  5'h05, 1, 1, 0, 0);   // 1  basic capture
    add(0, 1, 4'd5,  0, 1,  5'h00, 0, 0, 0, 0);   // 2  pop
    add(0, 1, 4'd1,  1, 0,  5'h01, 1, 1, 0, 0);   // 3  fill
    add(0, 1, 4'd2,  1, 0,  5'h01, 1, 2, 0, 0);   // 4
    add(0, 1, 4'd3,  1, 0,  5'h01, 1, 3, 0, 0);   // 5
    add(0, 1, 4'd4,  1, 0,  5'h01, 1, 4, 1, 0);   // 6  full
    add(0, 1, 4'd6,  1, 0,  5'h01, 1, 4, 1, 1);   // 7  dropped -> overflow
    add(0, 1, 4'd9,  1, 1,  5'h02, 1, 4, 1, 1);   // 8  push+pop while full
    add(0, 1, 4'd9,  0, 1,  5'h03, 1, 3, 0, 1);   // 9  drain
    add(0, 1, 4'd9,  0, 1,  5'h04, 1, 2, 0, 1);   // 10
    add(0, 1, 4'd9,  0, 1,  5'h09, 1, 1, 0, 1);   // 11
    add(0, 1, 4'd9,  0, 1,  5'h00, 0, 0, 0, 1);   // 12
    add(0, 1, 4'd9,  0, 1,  5'h00, 0, 0, 0, 1);   // 13 pop when empty ignored
    add(0, 1, 4'd14, 0, 0,  5'h00, 0, 0, 0, 1);   // 14 wrap sequence
    add(0, 1, 4'd15, 0, 0,  5'h00, 0, 0, 0, 1);   // 15
    add(0, 1, 4'd0,  0, 0,  5'h00, 0, 0, 0, 1);   // 16 wrap event
    add(0, 1, 4'd1,  1, 0,  5'h11, 1, 1, 0, 1);   // 17 flagged entry
    add(0, 1, 4'd2,  1, 0,  5'h11, 1, 2, 0, 1);   // 18
    add(0, 1, 4'd2,  0, 1,  5'h02, 1, 1, 0, 1);   // 19 unflagged entry
    add(0, 1, 4'd2,  0, 1,  5'h00, 0, 0, 0, 1);   // 20
    add(0, 1, 4'd15, 0, 0,  5'h00, 0, 0, 0, 1);   // 21
    add(0, 0, 4'd0,  0, 0,  5'h00, 0, 0, 0, 1);   // 22 15->0 while disabled
    add(0, 0, 4'd0,  1, 0,  5'h00, 1, 1, 0, 1);   // 23 flag 0
    add(0, 1, 4'd0,  1, 1,  5'h10, 1, 1, 0, 1);   // 24 capture on wrap edge
    add(0, 1, 4'd1,  1, 1,  5'h01, 1, 1, 0, 1);   // 25 pending was cleared
    add(0, 1, 4'd1,  0, 1,  5'h00, 0, 0, 0, 1);   // 26
    add(0, 1, 4'd7,  1, 0,  5'h07, 1, 1, 0, 1);   // 27
    add(0, 1, 4'd8,  1, 0,  5'h07, 1, 2, 0, 1);   // 28
    add(0, 1, 4'd15, 1, 0,  5'h07, 1, 3, 0, 1);   // 29
    add(0, 1, 4'd0,  0, 0,  5'h07, 1, 3, 0, 1);   // 30 wrap pending, level 3
    add(1, 1, 4'd5,  1, 0,  5'h00, 0, 0, 0, 0);   // 31 reset beats capture
    add(0, 1, 4'd5,  1, 0,  5'h05, 1, 1, 0, 0);   // 32 flag 0 after reset
    add(0, 1, 4'd6,  1, 0,  5'h05, 1, 2, 0, 0);   // 33
    add(0, 1, 4'd7,  1, 0,  5'h05, 1, 3, 0, 0);   // 34
    add(0, 1, 4'd15, 1, 0,  5'h05, 1, 4, 1, 0);   // 35
    add(0, 1, 4'd0,  1, 0,  5'h05, 1, 4, 1, 1);   // 36 wrap + dropped capture
    add(0, 0, 4'd9,  0, 1,  5'h06, 1, 3, 0, 1);   // 37
    add(0, 0, 4'd9,  1, 0,  5'h06, 1, 4, 1, 1);   // 38 stores pending flag
    add(0, 0, 4'd9,  0, 1,  5'h07, 1, 3, 0, 1);   // 39
    add(0, 0, 4'd9,  0, 1,  5'h0F, 1, 2, 0, 1);   // 40
    add(0, 0, 4'd9,  0, 1,  5'h19, 1, 1, 0, 1);   // 41
    add(0, 0, 4'd9,  0, 1,  5'h00, 0, 0, 0, 1);   // 42

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].cnt, vecs[i].cap, vecs[i].rdy);
      chk("out_data",  i, 32'(out_data),  32'(vecs[i].e_data));
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
      chk("level",     i, 32'(level),     32'(vecs[i].e_level));
      chk("full",      i, 32'(full),      32'(vecs[i].e_full));
      chk("overflow",  i, 32'(overflow),  32'(vecs[i].e_ovf));
    end

    // Head must hold while the consumer stalls.
    step(0, 0, 4'd10, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 4'd3, 0, 0);
      chk("hold_data",  100 + k, 32'(out_data), 32'h0A);
      chk("hold_level", 100 + k, 32'(level),    32'd1);
    end

    // Reset with capture and out_ready both active discards everything.
    step(1, 1, 4'd4, 1, 1);
    chk("rst_valid", 200, 32'(out_valid), 32'd0);
    chk("rst_level", 200, 32'(level),     32'd0);
    chk("rst_ovf",   200, 32'(overflow),  32'd0);
    chk("rst_data",  200, 32'(out_data),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_capture_fifo.md
COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter CW, default 4: counter value width.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: the upstream counter's enable; qualifies wrap detection.
REQ-006 SHALL have port counter_in, input, CW: live value from the upstream counter.
REQ-007 SHALL have port capture, input, 1: one-cycle request to snapshot counter_in.
REQ-008 SHALL have port out_data, output, CW+1: head entry {wrap_flag, count}; wrap_flag is the MSB.
REQ-009 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts head when out_valid && out_ready.
REQ-011 SHALL have port full, output, 1: level == DEPTH.
REQ-012 SHALL have port level, output, 5: number of stored entries.
REQ-013 SHALL have port overflow, output, 1: sticky; a capture was dropped.

Function
REQ-014 SHALL define push = capture && (!full || pop), where pop = out_valid && out_ready.
REQ-015 SHALL write {wrap_flag, counter_in} on the edge where push is true; the entry is visible on out_data/out_valid from the following cycle (1-cycle latency).
REQ-016 SHALL remove the head on the edge where pop is true; out_data SHALL hold stable while out_valid && !out_ready.
REQ-017 SHALL leave level unchanged on simultaneous push and pop, including when full; with level == 0 and capture, there is no pop that cycle (no fall-through).
REQ-018 SHALL drop a capture while full && !pop, leave FIFO contents unchanged, and set overflow; overflow clears only on reset.
REQ-019 SHALL ignore pop attempts when empty: out_ready with out_valid == 0 has no effect.
REQ-020 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH; level SHALL be the exact occupancy 0..DEPTH.
REQ-021 SHALL register prev_cnt and prev_ok: prev_cnt <= counter_in and prev_ok <= 1 on every edge with enable == 1; both hold when enable == 0.
REQ-022 SHALL detect a wrap event on an edge with enable && prev_ok && prev_cnt == all-ones && counter_in == 0.
REQ-023 SHALL set wrap_pending on a wrap event and clear it on push.
REQ-024 SHALL set the stored wrap_flag = wrap_pending || wrap_event that cycle; on push coincident with a wrap event, the flag is 1 and wrap_pending ends 0.
REQ-025 SHALL keep wrap_pending set when a capture is dropped (overflow).
REQ-026 SHALL let capture act regardless of enable; enable gates only wrap tracking.

Reset
REQ-027 SHALL, while reset is high at an edge, clear pointers, level = 0, out_valid = 0, full = 0, overflow = 0, wrap_pending = 0, prev_ok = 0, prev_cnt = 0.
REQ-028 SHALL drive out_data = 0 while empty after reset; entry storage need not be cleared.
REQ-029 SHALL give reset priority over capture, out_ready and enable in the same cycle; reset mid-stream discards all entries.
REQ-030 SHALL NOT detect a wrap on the first enabled edge after reset (prev_ok == 0).

Verification
REQ-031 SHALL cover basic capture: reset, enable=1, counter_in=5, capture one cycle, out_ready=0 -> next cycle out_valid=1, out_data=5'b0_0101, level=1; out_ready=1 -> next cycle out_valid=0, level=0.
REQ-032 SHALL cover overflow: DEPTH=4, captures of 1,2,3,4,6 with out_ready=0 -> full=1 after the fourth, fifth dropped, overflow=1, pops return 1,2,3,4 in order.
REQ-033 SHALL cover full with simultaneous push and pop: full, capture of 9 with out_ready=1 -> head 1 popped, 9 stored, level stays 4, overflow unchanged.
REQ-034 SHALL cover the wrap flag: enable=1, counter_in 14,15,0,1 on successive cycles, capture at 1 -> entry 5'b1_0001; next capture at 2 -> 5'b0_0010.
REQ-035 SHALL cover wrap gating and coincident capture: enable=0 during a 15->0 transition -> flag 0; enable=1 with capture on the same edge counter_in goes 15->0 -> entry 5'b1_0000, wrap_pending=0 afterwards.
REQ-036 SHALL cover reset mid-operation: level=3, overflow=1, wrap_pending=1, assert reset one cycle with capture=1 -> level=0, out_valid=0, overflow=0; the next capture stores wrap_flag=0.
